regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (rdc/rd plus write enable) among NREQ writeback sources
//  (ALU, load unit, mul/div unit) using round-robin arbitration with valid/ready handshakes.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file geometry for the writeback arbiter and its bench.
package regfile_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam int NUM_REGS = 1 << REG_AW;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from (last grant + 1) and moves its pointer only
// when the caller reports that the grant was consumed (advance).
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] last_q, last_d;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = int'(last_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance && found) last_d = grant_idx;
  end

  // Pointer resets to the last index so requester 0 wins the first scan.
  always_ff @(posedge clk) begin
    if (!rst) last_q <= IW'(NREQ - 1);
    else      last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources and keeps
// the busy scoreboard for destinations of in-flight multicycle ops.
// Handshake: a write transfers when req_valid[i] && req_ready[i]; req_ready is
// combinational, one-hot or zero, never set for a non-valid requester.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 wb_we,
  output logic [AW-1:0]        wb_addr,
  output logic [DW-1:0]        wb_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_ready,
  input  logic [AW-1:0]        chk_rs,
  input  logic [AW-1:0]        chk_rt,
  output logic                 busy_rs,
  output logic                 busy_rt,
  output logic [(1<<AW)-1:0]   busy_vec
);

  localparam int NR = 1 << AW;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  logic            wb_we_q, wb_we_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic [NR-1:0]   busy_q, busy_d;
  logic [NR-1:0]   clr_mask, set_mask;
  logic            commit_hit;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants are suppressed while reset is asserted so nothing is accepted.
  assign req_ready = rst ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    wb_we_d   = xfer && (sel_addr != AW'(REG_ZERO));
    wb_addr_d = xfer ? sel_addr : wb_addr_q;
    wb_data_d = xfer ? sel_data : wb_data_q;
  end

  // A register committing this cycle counts as free for a new reservation.
  assign commit_hit = wb_we_q && (wb_addr_q == rsv_addr);
  assign rsv_ready  = rst && (!busy_q[rsv_addr] || (rsv_addr == AW'(REG_ZERO)) || commit_hit);

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_we_q) clr_mask[wb_addr_q] = 1'b1;
    if (rsv_valid && rsv_ready && (rsv_addr != AW'(REG_ZERO))) set_mask[rsv_addr] = 1'b1;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wb_we    = wb_we_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign busy_vec = busy_q;
  assign busy_rs  = (chk_rs != AW'(REG_ZERO)) && busy_q[chk_rs];
  assign busy_rt  = (chk_rt != AW'(REG_ZERO)) && busy_q[chk_rt];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, writeback timing,
// scoreboard set/clear and the register-0 cases, with hand-computed expectations.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = REG_AW;
  localparam int DW   = REG_DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 wb_we;
  logic [AW-1:0]        wb_addr;
  logic [DW-1:0]        wb_data;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;
  logic                 rsv_ready;
  logic [AW-1:0]        chk_rs;
  logic [AW-1:0]        chk_rt;
  logic                 busy_rs;
  logic                 busy_rt;
  logic [NUM_REGS-1:0]  busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .chk_rs    (chk_rs),
    .chk_rt    (chk_rt),
    .busy_rs   (busy_rs),
    .busy_rt   (busy_rt),
    .busy_vec  (busy_vec)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after posedge; checks follow a further 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [NUM_REGS-1:0] exp_busy;
  int unsigned         seq[6] = '{0, 1, 2, 0, 1, 2};
  logic [AW-1:0]       addr_of[NREQ] = '{5'd1, 5'd2, 5'd3};

  initial begin
    rst       = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd4;
    chk_rs    = '0;
    chk_rt    = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, addr_of[i], 32'h1000_0000 + DW'(i));

    // 1: reset held 3 cycles with everything requesting
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_we", 64'(wb_we), 64'(0));
      check("rst_busy", 64'(busy_vec), 64'(0));
      check("rst_rsv_ready", 64'(rsv_ready), 64'(0));
    end
    check("rst_wb_addr", 64'(wb_addr), 64'(0));
    check("rst_wb_data", 64'(wb_data), 64'(0));
    rst = 1'b1;
    rsv_valid = 1'b0;
    #1;
    check("release_grant0", 64'(req_ready), 64'(3'b001));

    // 3: all valid continuously -> 0,1,2,0,1,2 back to back
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        check("rr_grant", 64'(req_ready), 64'(3'b001 << seq[k]));
      end
      tick();
      check("rr_we", 64'(wb_we), 64'(1));
      check("rr_addr", 64'(wb_addr), 64'(addr_of[seq[k]]));
      check("rr_data", 64'(wb_data), 64'(32'h1000_0000 + seq[k]));
      if (k == 5) req_valid = '0;
      #1;
    end

    // 2: single write, 1-cycle latency, one-cycle pulse, address/data hold
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    #1;
    check("single_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    check("single_we", 64'(wb_we), 64'(1));
    check("single_addr", 64'(wb_addr), 64'(5));
    check("single_data", 64'(wb_data), 64'(32'hDEAD_BEEF));
    tick();
    check("single_we_off", 64'(wb_we), 64'(0));
    check("single_addr_hold", 64'(wb_addr), 64'(5));
    check("single_data_hold", 64'(wb_data), 64'(32'hDEAD_BEEF));

    // 4: reserve 8, reject a second reservation, clear on commit
    rsv_valid = 1'b1;
    rsv_addr  = 5'd8;
    chk_rs    = 5'd8;
    chk_rt    = 5'd7;
    #1;
    check("rsv8_ready", 64'(rsv_ready), 64'(1));
    tick();
    exp_busy = '0;
    exp_busy[8] = 1'b1;
    #1;
    check("rsv8_busy_vec", 64'(busy_vec), 64'(exp_busy));
    check("rsv8_busy_rs", 64'(busy_rs), 64'(1));
    check("rsv8_busy_rt", 64'(busy_rt), 64'(0));
    check("rsv8_again_ready", 64'(rsv_ready), 64'(0));
    rsv_valid = 1'b0;
    set_req(2, 5'd8, 32'h0000_0088);
    req_valid = 3'b100;
    #1;
    check("w8_grant2", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = '0;
    check("w8_commit_we", 64'(wb_we), 64'(1));
    check("w8_no_forward", 64'(busy_rs), 64'(1));
    tick();
    check("w8_cleared_rs", 64'(busy_rs), 64'(0));
    check("w8_cleared_vec", 64'(busy_vec), 64'(0));

    // 5: commit of 9 and new reservation of 9 in the same cycle
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    tick();
    rsv_valid = 1'b0;
    set_req(1, 5'd9, 32'h0000_0099);
    req_valid = 3'b010;
    #1;
    check("w9_grant1", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    #1;
    check("w9_commit_we", 64'(wb_we), 64'(1));
    check("w9_rsv_ready", 64'(rsv_ready), 64'(1));
    tick();
    rsv_valid = 1'b0;
    exp_busy = '0;
    exp_busy[9] = 1'b1;
    check("w9_rereserved", 64'(busy_vec), 64'(exp_busy));

    // 6: address 0 consumes the grant and moves the pointer but never writes
    set_req(2, 5'd10, 32'h0000_00AA);
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    set_req(1, REG_ZERO, 32'h0000_0BAD);
    req_valid = 3'b010;
    #1;
    check("z_ready", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = '0;
    check("z_we_low", 64'(wb_we), 64'(0));
    for (int i = 0; i < NREQ; i++) set_req(i, addr_of[i], 32'h2000_0000);
    req_valid = 3'b111;
    #1;
    check("z_ptr_advanced", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_addr  = REG_ZERO;
    chk_rs    = REG_ZERO;
    #1;
    check("z_rsv_ready", 64'(rsv_ready), 64'(1));
    check("z_busy_rs", 64'(busy_rs), 64'(0));
    tick();
    rsv_valid = 1'b0;
    check("z_rsv_ignored", 64'(busy_vec), 64'(exp_busy));

    // Reset mid-operation drops the in-flight write and all reservations
    set_req(0, 5'd12, 32'h0000_0CCC);
    req_valid = 3'b001;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd13;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'(0));
    check("mid_rst_rsv_ready", 64'(rsv_ready), 64'(0));
    tick();
    check("mid_rst_we", 64'(wb_we), 64'(0));
    check("mid_rst_busy", 64'(busy_vec), 64'(0));
    req_valid = '0;
    rsv_valid = 1'b0;
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
